cp0_v2: RTL
===========

# cp0_v2

Parametrised second-generation coprocessor 0: architectural control registers, exception state capture, a Count/Compare timer interrupt, and TLB management registers (Index, Random, Wired, EntryHi/Lo, PageMask) sized by TLB depth. Sits beside the writeback/exception stage. It serves MFC0/MTC0 and records exceptions and ERET. It feeds EPC, interrupt state and TLB operands to the pipeline and the TLB.

## Interface
- TLB_ENTRIES, 16: TLB depth, power of two, 2..64; IDX_W = $clog2(TLB_ENTRIES).
- COUNT_DIV, 2: core cycles per Count increment, 1..16.
- PRID, 32'h0001_8000: constant PRId (reg 15 sel 0) value.
- Reset: rst, synchronous, active-high. Clock: clk.
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- hint in 6: hardware interrupt lines, sampled every cycle into Cause.IP[7:2].
- raddr in 8: {reg[4:0], sel[2:0]} read address.
- rdata out 32: combinational read data; 0 for unimplemented addresses.
- wen, waddr, wdata in 1/8/32: MTC0 write.
- exp_en, exp_bd, exp_code, exp_epc in 1/1/5/32: exception commit.
- exp_badvaddr_en, exp_badvaddr in 1/32: BadVAddr capture.
- exp_vpn2 in 19: faulting VPN2, loaded into EntryHi[31:13] on TLB exceptions (codes 1, 2, 3).
- eret in 1: ERET commit.
- tlbp_en, tlbp_hit, tlbp_index in 1/1/IDX_W: TLBP result.
- tlbr_en, tlbr_entryhi, tlbr_lo0, tlbr_lo1, tlbr_pagemask in 1/32/32/32/32: TLBR result.
- epc_address out 32: EPC.
- allow_interrupt out 1: Status.IE & ~EXL & ~ERL.
- interrupt_flag out 8: Status.IM & Cause.IP.
- timer_int out 1: Cause.TI.
- tlb_index, tlb_random out IDX_W: Index[IDX_W-1:0] and Random, for TLBWI/TLBWR.
- entryhi, entrylo0, entrylo1, pagemask out 32: current register values.

## Operation
- Writable fields:
  - Status: IM[15:8], ERL[2], EXL[1], IE[0]. BEV[22] is read-only 1.
  - Cause: IP[9:8].
  - EPC: all bits.
  - EntryHi: [31:13] and [7:0].
  - EntryLo0/1: [29:0].
  - PageMask: [24:13].
  - Index: [IDX_W-1:0].
  - Wired: [IDX_W-1:0].
  - Compare and Count: all bits.
  - All other bits read 0.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments on wrap.
  - Count increments into value == Compare: TI set next cycle.
  - Cause.IP[7] = hint[5] | TI.
  - MTC0 Compare clears TI.
  - MTC0 Count loads wdata and clears the prescaler.
- Random:
  - Decrements every cycle.
  - At Wired (or below Wired), it wraps to TLB_ENTRIES-1.
  - MTC0 Wired also sets Random = TLB_ENTRIES-1.
- Exception (exp_en):
  - EXL=1.
  - Cause.BD=exp_bd; Cause.ExcCode=exp_code.
  - If EXL was 0: EPC=exp_epc. If EXL was already 1: EPC unchanged.
  - BadVAddr loaded if exp_badvaddr_en.
  - EntryHi.VPN2 loaded on codes 1/2/3.
- eret: clears ERL if set, else clears EXL.
- tlbp_en:
  - Index[31] = ~tlbp_hit.
  - Index[IDX_W-1:0] = tlbp_index on hit; unchanged on miss.
- tlbr_en: loads EntryHi, EntryLo0/1 and PageMask, applying the writable-field masks.
- Same-cycle priority, per field: exp_en > eret > tlbp/tlbr > wen > timer/Random update.

## Timing
- rdata is combinational. A write is visible on rdata from the cycle after it; there is no write-to-read bypass.
- All outputs are registered-state derived, with zero-cycle combinational decode.
- Reset values:
  - Status=32'h0040_0000; Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0; prescaler=0; TI=0.
  - Index=0; Wired=0; Random=TLB_ENTRIES-1.
  - EntryHi/Lo0/Lo1/PageMask=0.
  - Hence allow_interrupt=0, interrupt_flag=0, timer_int=0, epc_address=0.
- Reset mid-operation discards pending TI and the prescaler phase.
- Count wraps 32'hFFFF_FFFF -> 0 silently.
- At reset Count==Compare, but TI is not set; only an increment into equality sets TI.

## Structure
- Package cp0_pkg holds:
  - Register address localparams (CP0_INDEX, CP0_RANDOM, … CP0_PRID).
  - An exc_code_t enum covering Int, Mod, TLBL, TLBS, AdEL, AdES, Sys, Bp, RI, Ov.
  - Writable-field mask constants.
- Sub-module cp0_timer holds Count, Compare, the prescaler and TI. Its interface is count_we, compare_we, wdata, count, compare, ti.

## Test plan
- Reset, then read 12/0 and 1/0 -> rdata 32'h0040_0000 and 15 (TLB_ENTRIES=16); timer_int 0.
- COUNT_DIV=2; write Compare=5 -> Count reaches 5 at cycle 10 and timer_int=1 at cycle 11; interrupt_flag[7]=1 with IM7 set; writing Compare clears it next cycle.
- Write Wired=4 -> Random reads 15, then decrements to 4, then reads 15 again; it never reads below 4.
- exp_en with code 2, exp_epc=32'h8000_0100, EXL=0 -> EPC=32'h8000_0100, Status[1]=1, EntryHi[31:13]=exp_vpn2. A second exp_en leaves EPC unchanged. eret -> EXL=0.
- Same cycle wen to EPC=32'h1234 and exp_en with exp_epc=32'h5678 -> EPC=32'h5678.
- tlbp_en with hit=0 -> Index=32'h8000_0000 | old index. tlbr_en with lo0=32'hFFFF_FFFF -> EntryLo0=32'h3FFF_FFFF.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the second-generation CP0: register addresses,
// exception codes and the writable-field masks applied on MTC0 and TLBR.
package cp0_pkg;

  // Read/write addresses are {reg[4:0], sel[2:0]}.
  localparam logic [7:0] CP0_INDEX    = 8'h00;
  localparam logic [7:0] CP0_RANDOM   = 8'h08;
  localparam logic [7:0] CP0_ENTRYLO0 = 8'h10;
  localparam logic [7:0] CP0_ENTRYLO1 = 8'h18;
  localparam logic [7:0] CP0_PAGEMASK = 8'h28;
  localparam logic [7:0] CP0_WIRED    = 8'h30;
  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_ENTRYHI  = 8'h50;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;
  localparam logic [7:0] CP0_PRID     = 8'h78;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF07;
  localparam logic [31:0] STATUS_BEV     = 32'h0040_0000;
  localparam logic [31:0] CAUSE_WMASK    = 32'h0000_0300;
  localparam logic [31:0] ENTRYHI_WMASK  = 32'hFFFF_E0FF;
  localparam logic [31:0] ENTRYLO_WMASK  = 32'h3FFF_FFFF;
  localparam logic [31:0] PAGEMASK_WMASK = 32'h01FF_E000;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky
// timer interrupt, raised one cycle after Count steps into Compare.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [3:0]  r_pre;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        r_match_p1;
  logic        w_inc;
  logic [31:0] w_count_inc;

  assign w_inc       = (r_pre == 4'(COUNT_DIV - 1));
  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre      <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_ti       <= 1'b0;
      r_match_p1 <= 1'b0;
    end else begin
      if (count_we) begin
        r_count <= wdata;
        r_pre   <= '0;
      end else begin
        r_pre <= w_inc ? 4'd0 : r_pre + 4'd1;
        if (w_inc) r_count <= w_count_inc;
      end
      if (compare_we) r_compare <= wdata;
      // stage p1: equality seen on an increment, TI raised the cycle after
      r_match_p1 <= w_inc & ~count_we & ~compare_we & (w_count_inc == r_compare);
      if (compare_we)      r_ti <= 1'b0;
      else if (r_match_p1) r_ti <= 1'b1;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

// File: rtl/cp0_v2.sv
// Coprocessor 0: control/status registers, exception capture, ERET handling
// and TLB management registers, with the Count/Compare timer as a sub-block.
module cp0_v2
  import cp0_pkg::*;
#(
  parameter int          TLB_ENTRIES = 16,
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] PRID        = 32'h0001_8000,
  localparam int         IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       hint,
  input  logic [7:0]       raddr,
  output logic [31:0]      rdata,
  input  logic             wen,
  input  logic [7:0]       waddr,
  input  logic [31:0]      wdata,
  input  logic             exp_en,
  input  logic             exp_bd,
  input  logic [4:0]       exp_code,
  input  logic [31:0]      exp_epc,
  input  logic             exp_badvaddr_en,
  input  logic [31:0]      exp_badvaddr,
  input  logic [18:0]      exp_vpn2,
  input  logic             eret,
  input  logic             tlbp_en,
  input  logic             tlbp_hit,
  input  logic [IDX_W-1:0] tlbp_index,
  input  logic             tlbr_en,
  input  logic [31:0]      tlbr_entryhi,
  input  logic [31:0]      tlbr_lo0,
  input  logic [31:0]      tlbr_lo1,
  input  logic [31:0]      tlbr_pagemask,
  output logic [31:0]      epc_address,
  output logic             allow_interrupt,
  output logic [7:0]       interrupt_flag,
  output logic             timer_int,
  output logic [IDX_W-1:0] tlb_index,
  output logic [IDX_W-1:0] tlb_random,
  output logic [31:0]      entryhi,
  output logic [31:0]      entrylo0,
  output logic [31:0]      entrylo1,
  output logic [31:0]      pagemask
);

  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

  logic [31:0]      r_status, r_epc, r_badvaddr, r_entryhi, r_lo0, r_lo1, r_pagemask;
  logic             r_bd, r_index_p;
  logic [4:0]       r_exc;
  logic [1:0]       r_ip_sw;
  logic [5:0]       r_hint;
  logic [IDX_W-1:0] r_index, r_wired, r_random;
  logic [31:0]      w_status_nxt, w_entryhi_nxt, w_count, w_compare, w_cause;
  logic [7:0]       w_ip;
  logic             w_ti, w_tlb_exc;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wen && waddr == CP0_COUNT),
    .compare_we (wen && waddr == CP0_COMPARE),
    .wdata      (wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  assign w_tlb_exc = (exp_code == EXC_MOD) || (exp_code == EXC_TLBL) || (exp_code == EXC_TLBS);

  // Later assignments win: exception > eret > TLB ops > MTC0.
  always_comb begin
    w_status_nxt = r_status;
    if (wen && waddr == CP0_STATUS) w_status_nxt = wdata & STATUS_WMASK;
    if (eret) begin
      if (r_status[2]) w_status_nxt[2] = 1'b0;
      else             w_status_nxt[1] = 1'b0;
    end
    if (exp_en) w_status_nxt[1] = 1'b1;

    w_entryhi_nxt = r_entryhi;
    if (wen && waddr == CP0_ENTRYHI) w_entryhi_nxt = wdata & ENTRYHI_WMASK;
    if (tlbr_en) w_entryhi_nxt = tlbr_entryhi & ENTRYHI_WMASK;
    if (exp_en && w_tlb_exc) w_entryhi_nxt[31:13] = exp_vpn2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_entryhi  <= '0;
      r_lo0      <= '0;
      r_lo1      <= '0;
      r_pagemask <= '0;
      r_bd       <= 1'b0;
      r_exc      <= '0;
      r_ip_sw    <= '0;
      r_hint     <= '0;
      r_index_p  <= 1'b0;
      r_index    <= '0;
      r_wired    <= '0;
      r_random   <= RAND_TOP;
    end else begin
      r_status  <= w_status_nxt;
      r_entryhi <= w_entryhi_nxt;
      r_hint    <= hint;
      if (wen && waddr == CP0_CAUSE)    r_ip_sw <= wdata[9:8];
      if (wen && waddr == CP0_EPC)      r_epc   <= wdata;
      if (wen && waddr == CP0_ENTRYLO0) r_lo0   <= wdata & ENTRYLO_WMASK;
      if (wen && waddr == CP0_ENTRYLO1) r_lo1   <= wdata & ENTRYLO_WMASK;
      if (wen && waddr == CP0_PAGEMASK) r_pagemask <= wdata & PAGEMASK_WMASK;
      if (wen && waddr == CP0_INDEX)    r_index <= wdata[IDX_W-1:0];
      if (wen && waddr == CP0_WIRED)    r_wired <= wdata[IDX_W-1:0];
      if (tlbr_en) begin
        r_lo0      <= tlbr_lo0 & ENTRYLO_WMASK;
        r_lo1      <= tlbr_lo1 & ENTRYLO_WMASK;
        r_pagemask <= tlbr_pagemask & PAGEMASK_WMASK;
      end
      if (tlbp_en) begin
        r_index_p <= ~tlbp_hit;
        if (tlbp_hit) r_index <= tlbp_index;
      end
      if (exp_en) begin
        r_bd  <= exp_bd;
        r_exc <= exp_code;
        if (!r_status[1])    r_epc      <= exp_epc;
        if (exp_badvaddr_en) r_badvaddr <= exp_badvaddr;
      end
      // Random never drops below Wired; writing Wired restarts it at the top.
      if (wen && waddr == CP0_WIRED) r_random <= RAND_TOP;
      else if (r_random <= r_wired)  r_random <= RAND_TOP;
      else                           r_random <= r_random - 1'b1;
    end
  end

  assign w_ip    = {r_hint[5] | w_ti, r_hint[4:0], r_ip_sw};
  assign w_cause = {r_bd, 15'd0, w_ip, 1'b0, r_exc, 2'b00};

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_INDEX:    rdata = {r_index_p, {(31 - IDX_W){1'b0}}, r_index};
      CP0_RANDOM:   rdata = {{(32 - IDX_W){1'b0}}, r_random};
      CP0_ENTRYLO0: rdata = r_lo0;
      CP0_ENTRYLO1: rdata = r_lo1;
      CP0_PAGEMASK: rdata = r_pagemask;
      CP0_WIRED:    rdata = {{(32 - IDX_W){1'b0}}, r_wired};
      CP0_BADVADDR: rdata = r_badvaddr;
      CP0_COUNT:    rdata = w_count;
      CP0_ENTRYHI:  rdata = r_entryhi;
      CP0_COMPARE:  rdata = w_compare;
      CP0_STATUS:   rdata = r_status | STATUS_BEV;
      CP0_CAUSE:    rdata = w_cause;
      CP0_EPC:      rdata = r_epc;
      CP0_PRID:     rdata = PRID;
      default:      rdata = '0;
    endcase
  end

  assign epc_address     = r_epc;
  assign allow_interrupt = r_status[0] & ~r_status[1] & ~r_status[2];
  assign interrupt_flag  = r_status[15:8] & w_ip;
  assign timer_int       = w_ti;
  assign tlb_index       = r_index;
  assign tlb_random      = r_random;
  assign entryhi         = r_entryhi;
  assign entrylo0        = r_lo0;
  assign entrylo1        = r_lo1;
  assign pagemask        = r_pagemask;

endmodule
